// File: rtl/event_reader.sv
// rtl/event_reader.sv - drains one complete capture window per packet onto a valid/ready stream
module event_reader #(
  parameter int          WIN_LEN  = 100,
  parameter logic [15:0] HDR_WORD = 16'hA55A,
  parameter int          CNT_W    = 10
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic [15:0]      fifo_dout,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_rd_data_count,
  output logic             fifo_rd_en,
  output logic [15:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy,
  output logic [15:0]      event_num
);

  localparam int              RC_W     = $clog2(WIN_LEN + 1);
  localparam logic [RC_W-1:0] WIN_END  = RC_W'(WIN_LEN);
  localparam logic [RC_W-1:0] WIN_LAST = RC_W'(WIN_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_NUM, S_DATA, S_CSUM} state_t;

  state_t          state;
  logic [15:0]     skid_data;
  logic            skid_valid;
  logic            rd_pend;
  logic [RC_W-1:0] rd_cnt;
  logic [RC_W-1:0] acc_cnt;
  logic [15:0]     csum;
  logic            accept;
  logic            window_ready;
  logic [1:0]      occ;

  assign accept       = tx_valid & tx_ready;
  assign window_ready = (fifo_rd_data_count >= CNT_W'(WIN_LEN));

  // Samples held or arriving once this cycle's accepted head has left.
  assign occ = {1'b0, tx_valid} + {1'b0, skid_valid} + {1'b0, rd_pend} - {1'b0, accept};

  // The first sample is prefetched while the number word is on the bus to hide read latency.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!fifo_empty) begin
      if (state == S_NUM)
        fifo_rd_en = (rd_cnt == '0);
      else if (state == S_DATA)
        fifo_rd_en = (rd_cnt < WIN_END) && (occ < 2'd2);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      busy       <= 1'b0;
      event_num  <= '0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      rd_pend    <= 1'b0;
      rd_cnt     <= '0;
      acc_cnt    <= '0;
      csum       <= '0;
    end else begin
      rd_pend <= fifo_rd_en;
      if (fifo_rd_en)
        rd_cnt <= rd_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (window_ready) begin
            state    <= S_HDR;
            busy     <= 1'b1;
            tx_data  <= HDR_WORD;
            tx_valid <= 1'b1;
          end
        end

        S_HDR: begin
          if (accept) begin
            state   <= S_NUM;
            tx_data <= event_num;
          end
        end

        S_NUM, S_DATA: begin
          if (state == S_DATA && accept) begin
            csum    <= csum + tx_data;
            acc_cnt <= acc_cnt + 1'b1;
          end
          if (state == S_DATA && accept && acc_cnt == WIN_LAST) begin
            state    <= S_CSUM;
            tx_data  <= csum + tx_data;
            tx_valid <= 1'b1;
            tx_last  <= 1'b1;
          end else begin
            if (state == S_NUM && accept)
              state <= S_DATA;
            // Two-entry buffer: tx_data is the head, skid_data the second slot.
            if (accept) begin
              if (skid_valid) begin
                tx_data    <= skid_data;
                tx_valid   <= 1'b1;
                skid_valid <= rd_pend;
                skid_data  <= fifo_dout;
              end else begin
                tx_valid <= rd_pend;
                if (rd_pend)
                  tx_data <= fifo_dout;
              end
            end else if (rd_pend) begin
              if (tx_valid) begin
                skid_data  <= fifo_dout;
                skid_valid <= 1'b1;
              end else begin
                tx_data  <= fifo_dout;
                tx_valid <= 1'b1;
              end
            end
          end
        end

        S_CSUM: begin
          if (accept) begin
            state     <= S_IDLE;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            event_num <= event_num + 16'd1;
            csum      <= '0;
            rd_cnt    <= '0;
            acc_cnt   <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_reader.sv
// tb/tb_event_reader.sv - scoreboarded random test of event_reader against a packet-level model
`timescale 1ns/1ps
module tb_event_reader;

  localparam int          WIN_LEN = 100;
  localparam logic [15:0] HDR     = 16'hA55A;
  localparam int          CNT_W   = 10;

  logic             rd_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic [15:0]      fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic [CNT_W-1:0] fifo_rd_data_count = '0;
  logic             fifo_rd_en;
  logic [15:0]      tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             tx_last;
  logic             busy;
  logic [15:0]      event_num;

  event_reader #(.WIN_LEN(WIN_LEN), .HDR_WORD(HDR), .CNT_W(CNT_W)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_data_count(fifo_rd_data_count), .fifo_rd_en(fifo_rd_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .event_num(event_num)
  );

  always #5 rd_clk = ~rd_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] rest_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] e_word;
  logic        force_empty = 1'b0;
  bit          rnd_ready = 1'b0;
  int          rd_pulses = 0, pops = 0, word_idx = 0, words_acc = 0;
  int          busy_cycles = 0, tv_low = 0;
  logic [15:0] model_evt = '0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Non-FWFT FIFO: data appears the cycle after the read strobe.
  always @(posedge rd_clk) begin
    if (rst_n && fifo_rd_en) begin
      rd_pulses++;
      check("rd_en_while_empty", int'(fifo_empty), 0);
      if (fifo_q.size() > 0) begin
        fifo_dout <= fifo_q.pop_front();
        pops++;
      end
    end
  end

  always @(negedge rd_clk) begin
    fifo_empty         = force_empty || (fifo_q.size() == 0);
    fifo_rd_data_count = CNT_W'(fifo_q.size());
  end

  // Monitor: every accepted word is checked against the scoreboard queue.
  always @(negedge rd_clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (busy && !tx_valid) tv_low++;
      if (prev_stall) begin
        check("hold_valid", int'(tx_valid), 1);
        check("hold_word", int'({tx_last, tx_data}), int'(prev_word));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_last, tx_data};
      if (tx_valid && tx_ready) begin
        words_acc++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", int'({tx_last, tx_data}), -1);
        end else begin
          e_word = exp_q.pop_front();
          check("stream_word", int'({tx_last, tx_data}), int'(e_word));
        end
        word_idx = tx_last ? 0 : word_idx + 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge rd_clk);
      #1;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // mode 0: ramp 0..WIN_LEN-1, 1: random, 2: all FFFF. Only n_now words enter the FIFO now.
  task automatic load_window(input int mode, input int n_now);
    int          sum;
    logic [15:0] w;
    sum = 0;
    @(posedge rd_clk);
    #2;
    rd_pulses = 0; pops = 0; busy_cycles = 0; words_acc = 0;
    exp_q.push_back({1'b0, HDR});
    exp_q.push_back({1'b0, model_evt});
    for (int i = 0; i < WIN_LEN; i++) begin
      case (mode)
        0:       w = 16'(i);
        1:       w = 16'($urandom);
        default: w = 16'hFFFF;
      endcase
      if (i < n_now) fifo_q.push_back(w);
      else           rest_q.push_back(w);
      exp_q.push_back({1'b0, w});
      sum += int'(w);
    end
    exp_q.push_back({1'b1, 16'(sum)});
    model_evt++;
  endtask

  task automatic finish_packet(input string name, input bit full_rate);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(negedge rd_clk);
      t++;
    end
    check({name, "_completed"}, int'(t < 5000), 1);
    @(negedge rd_clk);
    check({name, "_rd_pulses"}, rd_pulses, WIN_LEN);
    check({name, "_words"}, words_acc, WIN_LEN + 3);
    check({name, "_event_num"}, int'(event_num), int'(model_evt));
    check({name, "_fifo_drained"}, fifo_q.size(), 0);
    if (full_rate)
      check({name, "_rate"}, int'(busy_cycles <= WIN_LEN + 4), 1);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge rd_clk);
    #2 rst_n = 1'b1;
    @(negedge rd_clk);
    check("reset_tx_valid", int'(tx_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rd_en", int'(fifo_rd_en), 0);
    check("reset_event_num", int'(event_num), 0);
    check("reset_tx_data", int'(tx_data), 0);

    load_window(0, WIN_LEN);
    finish_packet("basic0", 1'b1);
    load_window(0, WIN_LEN);
    finish_packet("basic1", 1'b1);

    rnd_ready = 1'b1;
    load_window(0, WIN_LEN);
    finish_packet("bp_ramp", 1'b0);
    for (int k = 0; k < 2; k++) begin
      load_window(1, WIN_LEN);
      finish_packet("bp_rand", 1'b0);
    end
    rnd_ready = 1'b0;

    load_window(1, WIN_LEN - 1);
    repeat (20) @(negedge rd_clk);
    check("thresh_no_rd", rd_pulses, 0);
    check("thresh_idle", busy_cycles, 0);
    check("thresh_no_valid", int'(tx_valid), 0);
    @(posedge rd_clk);
    #2;
    while (rest_q.size() > 0) fifo_q.push_back(rest_q.pop_front());
    t = 0;
    while (!tx_valid && t < 4) begin
      @(negedge rd_clk);
      t++;
    end
    check("thresh_hdr_latency", int'(t <= 2), 1);
    finish_packet("thresh", 1'b1);

    load_window(2, WIN_LEN);
    finish_packet("csum_wrap", 1'b1);

    load_window(1, WIN_LEN);
    t = 0;
    while (pops < 41 && t < 2000) begin
      @(negedge rd_clk);
      t++;
    end
    check("underflow_reach", int'(t < 2000), 1);
    @(posedge rd_clk);
    #2 force_empty = 1'b1;
    tv_low = 0;
    repeat (5) @(negedge rd_clk);
    check("underflow_paused", int'(tv_low >= 2), 1);
    @(posedge rd_clk);
    #2 force_empty = 1'b0;
    finish_packet("underflow", 1'b0);

    load_window(0, WIN_LEN);
    t = 0;
    while (word_idx < 52 && t < 2000) begin
      @(negedge rd_clk);
      t++;
    end
    check("midreset_reach", int'(t < 2000), 1);
    @(posedge rd_clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_tx_valid", int'(tx_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_rd_en", int'(fifo_rd_en), 0);
    check("midreset_event_num", int'(event_num), 0);
    check("midreset_tx_last", int'(tx_last), 0);
    exp_q.delete();
    fifo_q.delete();
    model_evt  = '0;
    word_idx   = 0;
    prev_stall = 1'b0;
    @(posedge rd_clk);
    #2 rst_n = 1'b1;
    load_window(1, WIN_LEN);
    finish_packet("post_reset", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/event_reader.md
Name: event_reader

Overview:
Read-side companion to the trigger-window capture FIFO. Waits until a complete event window is in the FIFO, then drains it. Emits the window as a framed packet on a valid/ready stream: header word, event number, WIN_LEN samples, checksum. Sits between the capture FIFO read port and the readout/serialiser logic, in the read clock domain.

Parameters:
WIN_LEN, 100, samples per event window (2..1023)
HDR_WORD, 16'hA55A, constant first word of every packet
CNT_W, 10, width of fifo_rd_data_count

Ports:
rd_clk  in  1  read-domain clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
fifo_dout  in  16  FIFO read data, valid exactly 1 cycle after a cycle with fifo_rd_en=1 (non-FWFT)
fifo_empty  in  1  FIFO empty flag
fifo_rd_data_count  in  CNT_W  FIFO occupancy seen from the read side
fifo_rd_en  out  1  FIFO read strobe
tx_data  out  16  packet word
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts the word when tx_valid&tx_ready
tx_last  out  1  high with the checksum word only
busy  out  1  high from leaving IDLE until the checksum word is accepted
event_num  out  16  number of packets completed since reset

Behaviour:
- Reset (async assert, sync release): state=IDLE; fifo_rd_en, tx_valid, tx_last, busy = 0; tx_data=0; event_num=0; checksum, counters and skid buffer cleared.
- Reset mid-packet: packet is abandoned immediately. The next packet starts with HDR_WORD and event number 0.
- States: IDLE -> HDR -> NUM -> DATA -> CSUM -> IDLE.
- IDLE:
  - If fifo_rd_data_count >= WIN_LEN, go to HDR next cycle and set busy.
  - Otherwise stay, with no reads.
- HDR: present HDR_WORD with tx_valid=1. On acceptance, go to NUM.
- NUM: present event_num. On acceptance, go to DATA.
- DATA, read side:
  - 2-entry output buffer (skid) plus an issued counter rd_cnt (0..WIN_LEN).
  - Assert fifo_rd_en only when all hold:
    - rd_cnt < WIN_LEN
    - fifo_empty=0
    - (buffered words + reads in flight) < 2 after this cycle's acceptance
  - fifo_rd_en is never asserted with fifo_empty=1, and never more than WIN_LEN times per packet.
- DATA, stream side:
  - Returning fifo_dout is written into the buffer 1 cycle after its rd_en.
  - Buffer head drives tx_data/tx_valid.
  - Samples leave in FIFO order, with no drop and no duplicate under any tx_ready pattern.
- Checksum: 16-bit sum, modulo 2^16, of the WIN_LEN sample words only. It accumulates on acceptance of each sample.
- After the WIN_LEN-th sample is accepted, go to CSUM.
- CSUM: present the checksum with tx_last=1. On acceptance:
  - event_num increments (wraps 16'hFFFF->0).
  - busy drops; return to IDLE and clear checksum and rd_cnt.
- Throughput: with tx_ready held 1 and the window present, a packet takes WIN_LEN+3 consecutive valid cycles. At most one bubble is allowed, at the NUM->DATA transition, for the first read latency.
- Stream rule: once tx_valid=1, tx_data and tx_last hold stable until accepted. tx_valid never drops without acceptance.
- FIFO empties unexpectedly in DATA: reads stall and tx_valid drops once the buffer drains. Resume where left off when fifo_empty falls; the word order is preserved.
- The count condition is checked only in IDLE. Further events accumulating during a packet are read as the next packet.

Test Plan:
- Reset check: pulse rst_n low asynchronously (between edges) -> fifo_rd_en=0, tx_valid=0, busy=0, event_num=0 immediately.
- Basic packet: preload FIFO with 0..99, tx_ready=1 -> A55A, 0000, 0..99, 1356 (sum 4950), with tx_last only on 1356 and 103 accepted words. event_num then reads 1. A second preloaded window yields number word 0001.
- Backpressure: same data, tx_ready random/alternating -> identical word sequence, exactly 100 fifo_rd_en pulses, tx_data stable while tx_valid&!tx_ready.
- Threshold: fifo_rd_data_count=99 -> stays IDLE with no rd_en and no tx_valid. Raising it to 100 -> HDR presented within 2 cycles.
- Checksum wrap: 100 samples of FFFF -> checksum FF9C. Underflow: force fifo_empty=1 for 5 cycles after sample 40 -> no rd_en while empty, stream pauses and resumes with sample 41.
- Reset mid-DATA at sample 50 -> outputs cleared. With a fresh window loaded, the next packet starts A55A, 0000.
